pc_fetch_sequencer: RTL

- Program-counter register and instruction-fetch sequencer for the word-addressed KGP-miniRISC core.
- Holds the current PC and drives it to the external PC incrementer, which returns PC+1, and to instruction memory. Selects the next PC from PC+1 or a branch/jump target.
- Runs a fetch FSM against a synchronous 1-cycle-latency instruction BRAM and hands instructions to decode over a valid/ready handshake.
- Supports branch redirect (flush) and a sticky halt.

---
 rtl/pc_fetch_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch FSM for the word-addressed miniRISC core.
// Issues a read to a 1-cycle BRAM, registers the result and presents it to decode.
module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [PC_WIDTH-1:0]    pc_plus1,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {REQ, RESP, HOLD, HALTED} state_t;

  state_t state, nxt;
  logic   hs;

  assign hs        = (state == HOLD) & instr_ready;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) state <= REQ;
    else      state <= nxt;
  end

  // Redirect wins over any handshake; HALTED only leaves through reset.
  always_comb begin
    nxt = state;
    case (state)
      REQ:     nxt = branch_taken ? REQ : RESP;
      RESP:    nxt = branch_taken ? REQ : HOLD;
      HOLD: begin
        if (branch_taken) nxt = REQ;
        else if (hs)      nxt = halt ? HALTED : REQ;
      end
      HALTED:  nxt = HALTED;
      default: nxt = REQ;
    endcase
  end

  always_comb begin
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      REQ:     imem_en     = 1'b1;
      HOLD:    instr_valid = 1'b1;
      HALTED:  halted      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        REQ: if (branch_taken) pc <= branch_target;
        RESP: begin
          if (branch_taken) pc <= branch_target;
          else begin
            instr    <= imem_data;
            instr_pc <= pc;
          end
        end
        HOLD: begin
          if (branch_taken) pc <= branch_target;
          else if (hs) begin
            fetch_count <= fetch_count + 32'd1;
            if (!halt) pc <= pc_plus1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
